// File: rtl/evm_pkg.sv
// evm_pkg: shared mode and FSM state encodings for the EVM front-panel controller
package evm_pkg;

    typedef enum logic [1:0] {
        MODE_VOTE   = 2'd0,
        MODE_RESULT = 2'd1,
        MODE_WINNER = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_RESULT = 2'd2,
        ST_WINNER = 2'd3
    } state_t;

endpackage

// File: rtl/evm_max_finder.sv
// evm_max_finder: combinational maximum tally and leader mask over all candidates
module evm_max_finder #(
    parameter int NUM_CAND = 4,
    parameter int VOTE_W   = 8
) (
    input  logic [NUM_CAND*VOTE_W-1:0] cand_votes,
    output logic [VOTE_W-1:0]          max_tally,
    output logic [NUM_CAND-1:0]        leader_mask
);

    // running maximum across all tallies
    always_comb begin
        max_tally = '0;
        for (int i = 0; i < NUM_CAND; i++)
            if (cand_votes[i*VOTE_W +: VOTE_W] > max_tally)
                max_tally = cand_votes[i*VOTE_W +: VOTE_W];
    end

    // every candidate matching the maximum is a leader, so ties light together
    always_comb begin
        leader_mask = '0;
        for (int i = 0; i < NUM_CAND; i++)
            leader_mask[i] = cand_votes[i*VOTE_W +: VOTE_W] == max_tally;
    end

endmodule

// File: rtl/evm_display_ctrl.sv
// evm_display_ctrl: EVM LED controller (vote acknowledge, tally display, winner display);
// define MODE_CTRL_BLINK_EN to blink the LEDs during the acknowledge instead of holding them solid
module evm_display_ctrl
    import evm_pkg::*;
#(
    parameter int NUM_CAND   = 4,
    parameter int VOTE_W     = 8,
    parameter int LED_W      = 8,
    parameter int ACK_CYCLES = 10,
    parameter int BLINK_DIV  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0]                 mode,
    input  logic                       valid_vote_casted,
    input  logic [NUM_CAND*VOTE_W-1:0] cand_votes,
    input  logic [NUM_CAND-1:0]        cand_button_press,
    output logic [LED_W-1:0]           leds,
    output logic                       ack_busy
);

    localparam int AW = $clog2(ACK_CYCLES) + 1;
    localparam int IW = $clog2(NUM_CAND);

    if (NUM_CAND < 2 || NUM_CAND > LED_W || ACK_CYCLES < 1 || BLINK_DIV < 1) begin : g_bad_param
        $error("evm_display_ctrl: parameter out of range");
    end

    state_t                state, state_n;
    logic [AW-1:0]         ack_cnt, ack_cnt_n;
    logic [IW-1:0]         sel_idx, sel_idx_n, press_idx, shown_idx;
    logic                  sel_valid, sel_valid_n;
    logic [LED_W-1:0]      leds_n, ack_leds, tally_leds;
    logic [VOTE_W-1:0]     max_tally;
    logic [NUM_CAND-1:0]   leader_mask;
    logic                  ack_load, ack_hold;

    evm_max_finder #(
        .NUM_CAND (NUM_CAND),
        .VOTE_W   (VOTE_W)
    ) u_max (
        .cand_votes  (cand_votes),
        .max_tally   (max_tally),
        .leader_mask (leader_mask)
    );

    // a tally too wide for the LED bus saturates to all-ones
    function automatic logic [LED_W-1:0] sat(input logic [VOTE_W-1:0] x);
        logic [VOTE_W+LED_W-1:0] w;
        w = {{LED_W{1'b0}}, x};
        return |w[VOTE_W+LED_W-1:LED_W] ? '1 : w[LED_W-1:0];
    endfunction

    // lowest-numbered pressed button wins when several are held
    always_comb begin
        press_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--)
            if (cand_button_press[i]) press_idx = IW'(i);
    end

    assign shown_idx  = |cand_button_press ? press_idx : sel_idx;
    assign tally_leds = sat(cand_votes[shown_idx*VOTE_W +: VOTE_W]);
    assign ack_load   = mode_t'(mode) == MODE_VOTE && valid_vote_casted;
    assign ack_hold   = mode_t'(mode) == MODE_VOTE && !valid_vote_casted && state == ST_ACK && ack_cnt != '0;

`ifdef MODE_CTRL_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV) + 1;

    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          blink_on, blink_on_n, blink_wrap;

    // blink phase restarts lit on every load and flips after BLINK_DIV cycles
    always_comb begin
        blink_wrap  = blink_cnt == BW'(BLINK_DIV - 1);
        blink_cnt_n = '0;
        blink_on_n  = 1'b1;
        if (ack_hold) begin
            blink_cnt_n = blink_wrap ? '0 : blink_cnt + 1'b1;
            blink_on_n  = blink_wrap ? ~blink_on : blink_on;
        end
    end

    // blink counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else begin
            blink_cnt <= blink_cnt_n;
            blink_on  <= blink_on_n;
        end
    end

    assign ack_leds = {LED_W{blink_on_n}};
`else
    assign ack_leds = '1;
`endif

    // next state, acknowledge countdown, selection latch and LED image from the sampled mode
    always_comb begin
        state_n     = ST_IDLE;
        ack_cnt_n   = '0;
        sel_idx_n   = sel_idx;
        sel_valid_n = sel_valid;
        leds_n      = '0;
        case (mode_t'(mode))
            MODE_VOTE: begin
                if (ack_load) begin
                    state_n   = ST_ACK;
                    ack_cnt_n = AW'(ACK_CYCLES - 1);
                    leds_n    = ack_leds;
                end else if (ack_hold) begin
                    state_n   = ST_ACK;
                    ack_cnt_n = ack_cnt - 1'b1;
                    leds_n    = ack_leds;
                end
            end
            MODE_RESULT: begin
                state_n = ST_RESULT;
                if (state != ST_RESULT) begin
                    sel_valid_n = 1'b0;
                end else if (|cand_button_press) begin
                    sel_idx_n   = press_idx;
                    sel_valid_n = 1'b1;
                    leds_n      = tally_leds;
                end else if (sel_valid) begin
                    leds_n = tally_leds;
                end
            end
            MODE_WINNER: begin
                state_n = ST_WINNER;
                leds_n  = max_tally == '0 ? '0 : LED_W'(leader_mask);
            end
            default: ;
        endcase
    end

    // state and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            ack_cnt   <= '0;
            sel_idx   <= '0;
            sel_valid <= 1'b0;
            leds      <= '0;
        end else begin
            state     <= state_n;
            ack_cnt   <= ack_cnt_n;
            sel_idx   <= sel_idx_n;
            sel_valid <= sel_valid_n;
            leds      <= leds_n;
        end
    end

    assign ack_busy = state == ST_ACK;

endmodule

// File: tb/tb_evm_display_ctrl.sv
// tb_evm_display_ctrl: directed and random checks of evm_display_ctrl against a behavioural model
module tb_evm_display_ctrl;

    localparam int ACK = 10;
    localparam int BD  = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        valid_vote_casted = 1'b0;
    logic [3:0]  cand_button_press = 4'd0;
    logic [7:0]  tv [4];
    logic [31:0] cand_votes;
    logic [39:0] cand_votes2 = '0;
    logic [7:0]  leds, leds2;
    logic        ack_busy, ack_busy2;

    int n_checks = 0;
    int n_fail = 0;

    int         m_left = 0;
    int         m_age = 0;
    int         m_sel = -1;
    bit         m_in_result = 0;
    logic [7:0] m_leds = '0;
    bit         m_busy = 0;

    assign cand_votes = {tv[3], tv[2], tv[1], tv[0]};

    always #5 clock = ~clock;

    evm_display_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .valid_vote_casted (valid_vote_casted),
        .cand_votes        (cand_votes),
        .cand_button_press (cand_button_press),
        .leds              (leds),
        .ack_busy          (ack_busy)
    );

    evm_display_ctrl #(
        .VOTE_W     (10),
        .ACK_CYCLES (8),
        .BLINK_DIV  (2)
    ) dut2 (
        .clock             (clock),
        .reset             (reset),
        .mode              (mode),
        .valid_vote_casted (valid_vote_casted),
        .cand_votes        (cand_votes2),
        .cand_button_press (cand_button_press),
        .leds              (leds2),
        .ack_busy          (ack_busy2)
    );

    function automatic bit blink_lit(input int age, input int div);
`ifdef MODE_CTRL_BLINK_EN
        return ((age / div) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_step();
        int mx;
        if (reset) begin
            m_left = 0;
            m_sel = -1;
            m_in_result = 0;
            m_leds = '0;
        end else if (mode == 2'd0) begin
            m_in_result = 0;
            if (valid_vote_casted) begin
                m_left = ACK;
                m_age = 0;
            end else if (m_left > 0) begin
                m_left--;
                m_age++;
            end
            m_leds = (m_left > 0 && blink_lit(m_age, BD)) ? 8'hFF : 8'h00;
        end else if (mode == 2'd1) begin
            if (!m_in_result) m_sel = -1;
            else if (cand_button_press != 0)
                for (int i = 3; i >= 0; i--) if (cand_button_press[i]) m_sel = i;
            m_leds = (m_sel < 0) ? 8'h00 : tv[m_sel];
            m_in_result = 1;
            m_left = 0;
        end else if (mode == 2'd2) begin
            mx = 0;
            for (int i = 0; i < 4; i++) if (int'(tv[i]) > mx) mx = int'(tv[i]);
            m_leds = '0;
            if (mx != 0)
                for (int i = 0; i < 4; i++) if (int'(tv[i]) == mx) m_leds[i] = 1'b1;
            m_in_result = 0;
            m_left = 0;
        end else begin
            m_leds = '0;
            m_left = 0;
            m_in_result = 0;
        end
        m_busy = m_left > 0;
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_vote_casted = 1'b1;
        mode = 2'd2;
        tv[0] = 8'd7; tv[1] = 8'd3; tv[2] = 8'd1; tv[3] = 8'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (leds !== 8'h00 || ack_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cycle %0d: leds=%h busy=%b, required leds=00 busy=0", i, leds, ack_busy);
            end
        end
        reset = 1'b0;
        valid_vote_casted = 1'b0;
        mode = 2'd0;
        tick();
        tick();
    endtask

    task automatic test_ack_single();
        logic [7:0] exp;
        mode = 2'd0;
        for (int i = 0; i < 12; i++) tick();
        valid_vote_casted = 1'b1;
        tick();
        valid_vote_casted = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp = (i < ACK && blink_lit(i, BD)) ? 8'hFF : 8'h00;
            n_checks++;
            if (leds !== exp || ack_busy !== (i < ACK)) begin
                n_fail++;
                $display("FAIL ack_single cycle %0d: leds=%h busy=%b, required leds=%h busy=%b", i, leds, ack_busy, exp, i < ACK);
            end
            tick();
        end
    endtask

    task automatic test_retrigger();
        int busy_cycles = 0;
        mode = 2'd0;
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 20; i++) begin
            valid_vote_casted = (i == 0 || i == 4);
            tick();
            if (ack_busy) busy_cycles++;
        end
        valid_vote_casted = 1'b0;
        n_checks++;
        if (busy_cycles != 14 || leds !== 8'h00) begin
            n_fail++;
            $display("FAIL retrigger: busy cycles=%0d final leds=%h, required 14 and 00", busy_cycles, leds);
        end
    endtask

    task automatic test_result();
        mode = 2'd1;
        cand_button_press = 4'd0;
        tv[0] = 8'h11; tv[1] = 8'h23; tv[2] = 8'h55; tv[3] = 8'h77;
        cand_votes2 = {10'd0, 10'd0, 10'd0, 10'd300, 10'd7};
        tick();
        n_checks++;
        if (leds !== 8'h00) begin
            n_fail++;
            $display("FAIL result_entry: leds=%h, required 00", leds);
        end
        cand_button_press = 4'b0110;
        tick();
        cand_button_press = 4'd0;
        n_checks++;
        if (leds !== 8'h23) begin
            n_fail++;
            $display("FAIL result_press: leds=%h, required 23", leds);
        end
        n_checks++;
        if (leds2 !== 8'hFF) begin
            n_fail++;
            $display("FAIL result_saturate: leds=%h, required FF", leds2);
        end
        tv[1] = 8'h24;
        tick();
        n_checks++;
        if (leds !== 8'h24) begin
            n_fail++;
            $display("FAIL result_live: leds=%h, required 24", leds);
        end
        cand_button_press = 4'b1000;
        tick();
        cand_button_press = 4'd0;
        n_checks++;
        if (leds !== 8'h77) begin
            n_fail++;
            $display("FAIL result_reselect: leds=%h, required 77", leds);
        end
        mode = 2'd2;
        tick();
        mode = 2'd1;
        tick();
        n_checks++;
        if (leds !== 8'h00) begin
            n_fail++;
            $display("FAIL result_reentry: leds=%h, required 00", leds);
        end
    endtask

    task automatic test_winner();
        mode = 2'd2;
        tv[0] = 8'd5; tv[1] = 8'd9; tv[2] = 8'd9; tv[3] = 8'd2;
        tick();
        n_checks++;
        if (leds !== 8'b0000_0110) begin
            n_fail++;
            $display("FAIL winner_tie: leds=%b, required 00000110", leds);
        end
        tv[0] = 8'd0; tv[1] = 8'd0; tv[2] = 8'd0; tv[3] = 8'd0;
        tick();
        n_checks++;
        if (leds !== 8'h00) begin
            n_fail++;
            $display("FAIL winner_zero: leds=%h, required 00", leds);
        end
        tv[3] = 8'd200;
        tick();
        n_checks++;
        if (leds !== 8'h08) begin
            n_fail++;
            $display("FAIL winner_single: leds=%h, required 08", leds);
        end
    endtask

    task automatic test_mode_switch();
        mode = 2'd0;
        tick();
        valid_vote_casted = 1'b1;
        tick();
        valid_vote_casted = 1'b0;
        tick();
        n_checks++;
        if (ack_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_busy: busy=%b, required 1", ack_busy);
        end
        mode = 2'd1;
        tick();
        n_checks++;
        if (ack_busy !== 1'b0 || leds !== 8'h00) begin
            n_fail++;
            $display("FAIL switch_drop: busy=%b leds=%h, required 0 and 00", ack_busy, leds);
        end
        mode = 2'd0;
        tick();
        n_checks++;
        if (ack_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_no_resume: busy=%b, required 0", ack_busy);
        end
        mode = 2'd3;
        valid_vote_casted = 1'b1;
        tick();
        valid_vote_casted = 1'b0;
        n_checks++;
        if (ack_busy !== 1'b0 || leds !== 8'h00) begin
            n_fail++;
            $display("FAIL reserved_mode: busy=%b leds=%h, required 0 and 00", ack_busy, leds);
        end
    endtask

    task automatic test_ack_short();
        logic [7:0] exp;
        mode = 2'd0;
        for (int i = 0; i < 12; i++) tick();
        valid_vote_casted = 1'b1;
        tick();
        valid_vote_casted = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp = (i < 8 && blink_lit(i, 2)) ? 8'hFF : 8'h00;
            n_checks++;
            if (leds2 !== exp || ack_busy2 !== (i < 8)) begin
                n_fail++;
                $display("FAIL ack_short cycle %0d: leds=%h busy=%b, required leds=%h busy=%b", i, leds2, ack_busy2, exp, i < 8);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            valid_vote_casted = ($urandom_range(0, 3) == 0);
            cand_button_press = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0)
                    tv[i] = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            tick();
            n_checks++;
            if (leds !== m_leds || ack_busy !== m_busy) begin
                n_fail++;
                $display("FAIL random cycle %0d mode %0d: leds=%h busy=%b, required leds=%h busy=%b", c, mode, leds, ack_busy, m_leds, m_busy);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) tv[i] = 8'd0;
        test_reset();
        test_ack_single();
        test_retrigger();
        test_result();
        test_winner();
        test_mode_switch();
        test_ack_short();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
